// File: rtl/dac_tx_pkg.sv
// Shared definitions for the parallel DAC transmit path: default bus width,
// midscale code and the two's-complement to offset-binary mapping.
package dac_tx_pkg;

    localparam int DAC_DW_DEFAULT = 12;

    typedef logic [15:0] ucnt_t;

    function automatic logic [31:0] midscale(input int dw);
        return 32'd1 << (dw - 1);
    endfunction

    // Offset binary is two's complement with the sign bit inverted.
    function automatic logic [31:0] to_offset_binary(input logic [31:0] x, input int dw);
        return x ^ (32'd1 << (dw - 1));
    endfunction

endpackage

// File: rtl/dac_parallel_tx_if.sv
// Sample stream into the DAC transmitter: valid/ready handshake with DW-bit data.
interface dac_parallel_tx_if
    import dac_tx_pkg::*;
#(
    parameter int DW = DAC_DW_DEFAULT
);
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_tx_fifo.sv
// Small synchronous first-word-fall-through FIFO buffering DAC samples.
module dac_tx_fifo
    import dac_tx_pkg::*;
#(
    parameter int DW         = DAC_DW_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r];

    // Sample storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge sys_clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/dac_parallel_tx.sv
// Parallel high-speed DAC driver: divided sample clock, FIFO-buffered data bus.
// Optional saturating underrun counter enabled by DAC_TX_UNDERRUN_CNT_EN.
module dac_parallel_tx
    import dac_tx_pkg::*;
#(
    parameter int DW         = DAC_DW_DEFAULT,
    parameter int DIV        = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int TWOS_COMP  = 0
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                enable,
    dac_parallel_tx_if.slave    s_if,
    output logic                dac_clk,
    output logic [DW-1:0]       dac_d,
`ifdef DAC_TX_UNDERRUN_CNT_EN
    output logic [15:0]         underrun_cnt,
`endif
    output logic                underrun
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt_r;
    logic          dac_clk_r;
    logic [DW-1:0] dac_d_r;
    logic          underrun_r;
    logic          at_wrap_s;
    logic          upd_s;
    logic          push_s;
    logic          pop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [DW-1:0] head_s;
    logic [DW-1:0] conv_s;

    // Update happens in the cycle where dac_clk is about to fall, giving the
    // DAC a full half-period of setup before its rising edge.
    assign at_wrap_s     = (div_cnt_r == CW'(DIV - 1));
    assign upd_s         = enable && at_wrap_s && dac_clk_r;
    assign s_if.s_ready  = rst_n && !fifo_full_s;
    assign push_s        = s_if.s_valid && s_if.s_ready;
    assign pop_s         = upd_s && !fifo_empty_s;

    dac_tx_fifo #(
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .pop     (pop_s),
        .din     (s_if.s_data),
        .dout    (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Input format conversion applied to the FIFO head.
    always_comb begin
        conv_s = head_s;
        if (TWOS_COMP != 0) begin
            conv_s = DW'(to_offset_binary(32'(head_s), DW));
        end else begin
            conv_s = head_s;
        end
    end

    // Clock divider; disabling parks dac_clk low with the phase reset.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            div_cnt_r <= CW'(0);
            dac_clk_r <= 1'b0;
        end else if (!enable) begin
            div_cnt_r <= CW'(0);
            dac_clk_r <= 1'b0;
        end else if (at_wrap_s) begin
            div_cnt_r <= CW'(0);
            dac_clk_r <= ~dac_clk_r;
        end else begin
            div_cnt_r <= div_cnt_r + CW'(1);
        end
    end

    // Data bus holds its last value on underrun.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            dac_d_r    <= DW'(midscale(DW));
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= upd_s && fifo_empty_s;
            if (pop_s) begin
                dac_d_r <= conv_s;
            end
        end
    end

`ifdef DAC_TX_UNDERRUN_CNT_EN
    ucnt_t ucnt_r;

    // Counts underrun events, saturating rather than wrapping.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            ucnt_r <= 16'h0000;
        end else if (upd_s && fifo_empty_s && (ucnt_r != 16'hFFFF)) begin
            ucnt_r <= ucnt_r + 16'h0001;
        end
    end

    assign underrun_cnt = ucnt_r;
`endif

    assign dac_clk  = dac_clk_r;
    assign dac_d    = dac_d_r;
    assign underrun = underrun_r;
endmodule

// File: tb/tb_dac_parallel_tx.sv
// Bench for dac_parallel_tx: three instances (plain DIV=1, two's-complement DIV=1,
// plain DIV=3) share one stimulus stream and are checked against a behavioural model.
module tb_dac_parallel_tx;
    logic sys_clk = 1'b0;
    logic rst_n;
    logic enable;
    logic s_valid;
    logic [11:0] s_data;

    logic [2:0]       dclk;
    logic [2:0][11:0] dd;
    logic [2:0]       und;
    logic [2:0]       rdy;
    logic [2:0][15:0] ucnt;

    int tests = 0;
    int fails = 0;

    always #5 sys_clk = ~sys_clk;

    dac_parallel_tx_if #(.DW(12)) bus0 ();
    dac_parallel_tx_if #(.DW(12)) bus1 ();
    dac_parallel_tx_if #(.DW(12)) bus2 ();

    assign bus0.s_data = s_data;  assign bus0.s_valid = s_valid;  assign rdy[0] = bus0.s_ready;
    assign bus1.s_data = s_data;  assign bus1.s_valid = s_valid;  assign rdy[1] = bus1.s_ready;
    assign bus2.s_data = s_data;  assign bus2.s_valid = s_valid;  assign rdy[2] = bus2.s_ready;

`ifndef DAC_TX_UNDERRUN_CNT_EN
    assign ucnt = '0;
`endif

    dac_parallel_tx #(.DW(12), .DIV(1), .FIFO_DEPTH(4), .TWOS_COMP(0)) dut0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .s_if(bus0),
        .dac_clk(dclk[0]), .dac_d(dd[0]),
`ifdef DAC_TX_UNDERRUN_CNT_EN
        .underrun_cnt(ucnt[0]),
`endif
        .underrun(und[0]));
    dac_parallel_tx #(.DW(12), .DIV(1), .FIFO_DEPTH(4), .TWOS_COMP(1)) dut1 (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .s_if(bus1),
        .dac_clk(dclk[1]), .dac_d(dd[1]),
`ifdef DAC_TX_UNDERRUN_CNT_EN
        .underrun_cnt(ucnt[1]),
`endif
        .underrun(und[1]));
    dac_parallel_tx #(.DW(12), .DIV(3), .FIFO_DEPTH(4), .TWOS_COMP(0)) dut2 (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .s_if(bus2),
        .dac_clk(dclk[2]), .dac_d(dd[2]),
`ifdef DAC_TX_UNDERRUN_CNT_EN
        .underrun_cnt(ucnt[2]),
`endif
        .underrun(und[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          divs [3] = '{1, 1, 3};
    bit          tcs  [3] = '{1'b0, 1'b1, 1'b0};
    int          m_run [3];   // consecutive enabled cycles since last disable/reset
    int          m_occ [3];
    int          m_hd  [3];
    logic [11:0] m_buf [3][4];
    logic [11:0] m_dd  [3];
    bit          m_und [3];
    int          m_cnt [3];
    bit          model_ok = 1'b0;

    function automatic logic [11:0] conv(input logic [11:0] x, input bit tc);
        return tc ? (x ^ 12'h800) : x;
    endfunction

    always @(posedge sys_clk) begin
        for (int i = 0; i < 3; i++) begin
            bit upd_m;
            bit psh_m;
            if (!rst_n) begin
                m_run[i] = 0; m_occ[i] = 0; m_hd[i] = 0;
                m_dd[i] = 12'h800; m_und[i] = 1'b0; m_cnt[i] = 0;
                model_ok = 1'b1;
            end else begin
                psh_m = s_valid && (m_occ[i] < 4);
                upd_m = 1'b0;
                if (enable) begin
                    m_run[i]++;
                    upd_m = (m_run[i] % (2 * divs[i])) == 0;
                end else begin
                    m_run[i] = 0;
                end
                m_und[i] = 1'b0;
                if (upd_m) begin
                    if (m_occ[i] > 0) begin
                        m_dd[i] = conv(m_buf[i][m_hd[i]], tcs[i]);
                        m_hd[i] = (m_hd[i] + 1) % 4;
                        m_occ[i]--;
                    end else begin
                        m_und[i] = 1'b1;
                        if (m_cnt[i] < 65535) m_cnt[i]++;
                    end
                end
                if (psh_m) begin
                    m_buf[i][(m_hd[i] + m_occ[i]) % 4] = s_data;
                    m_occ[i]++;
                end
            end
        end
    end

    // Compare process: every DUT output against the model, each cycle.
    always @(negedge sys_clk) begin
        #1;
        if (model_ok) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("dac_clk[%0d]", i), 32'(dclk[i]), 32'((m_run[i] / divs[i]) % 2));
                chk($sformatf("dac_d[%0d]", i), 32'(dd[i]), 32'(m_dd[i]));
                chk($sformatf("underrun[%0d]", i), 32'(und[i]), 32'(m_und[i]));
                chk($sformatf("s_ready[%0d]", i), 32'(rdy[i]), 32'(rst_n && (m_occ[i] < 4)));
`ifdef DAC_TX_UNDERRUN_CNT_EN
                chk($sformatf("underrun_cnt[%0d]", i), 32'(ucnt[i]), 32'(m_cnt[i]));
`endif
            end
        end
    end

    // Log of every change seen on each data bus.
    logic [11:0] log0[$], log1[$], log2[$];
    logic [2:0][11:0] prev_dd;
    always @(negedge sys_clk) begin
        if (dd[0] !== prev_dd[0]) log0.push_back(dd[0]);
        if (dd[1] !== prev_dd[1]) log1.push_back(dd[1]);
        if (dd[2] !== prev_dd[2]) log2.push_back(dd[2]);
        prev_dd = dd;
    end

    task automatic clr_logs();
        @(posedge sys_clk); #1;
        log0.delete(); log1.delete(); log2.delete();
    endtask

    // Offer one sample (call at a negedge) until the selected DUT accepts it.
    task automatic offer(input logic [11:0] d, input int sel);
        int n;
        bit acc;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        do begin
            acc = rdy[sel];
            @(posedge sys_clk);
            @(negedge sys_clk);
            n++;
        end while (!acc && n < 200);
        s_valid = 1'b0;
        if (!acc) chk("offer_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        logic [15:0] c0;
        logic [11:0] snap;
        logic prev_c;

        rst_n = 1'b0; enable = 1'b0; s_valid = 1'b1; s_data = 12'h3AB;
        prev_dd = '0;

        // 1. reset with s_valid held high
        repeat (3) @(negedge sys_clk);
        chk("rst_dac_clk", 32'(dclk[0]), 32'd0);
        chk("rst_dac_d", 32'(dd[0]), 32'h800);
        chk("rst_s_ready", 32'(rdy[0]), 32'd0);
        rst_n = 1'b1; s_valid = 1'b0;
        #1;
        chk("post_rst_s_ready", 32'(rdy[0]), 32'd1);
        chk("post_rst_dac_d", 32'(dd[0]), 32'h800);

        // 2. back-to-back stream at DIV=1
        clr_logs();
        @(negedge sys_clk);
        enable = 1'b1;
        offer(12'h000, 0); offer(12'h123, 0); offer(12'hFFF, 0);
        repeat (12) @(negedge sys_clk);
        chk("stream_len", 32'(log0.size()), 32'd3);
        chk("stream_0", 32'(log0[0]), 32'h000);
        chk("stream_1", 32'(log0[1]), 32'h123);
        chk("stream_2", 32'(log0[2]), 32'hFFF);
        chk("tc_stream_len", 32'(log1.size()), 32'd2);
        chk("tc_stream_0", 32'(log1[0]), 32'h923);
        chk("tc_stream_1", 32'(log1[1]), 32'h7FF);

        // 5. two's complement conversion
        clr_logs();
        @(negedge sys_clk);
        offer(12'h800, 0); offer(12'h000, 0); offer(12'h7FF, 0); offer(12'hFFF, 0);
        repeat (12) @(negedge sys_clk);
        chk("tc_len", 32'(log1.size()), 32'd4);
        chk("tc_800", 32'(log1[0]), 32'h000);
        chk("tc_000", 32'(log1[1]), 32'h800);
        chk("tc_7ff", 32'(log1[2]), 32'hFFF);
        chk("tc_fff", 32'(log1[3]), 32'h7FF);

        // 4. underrun after a single sample
        offer(12'h555, 0);
        n = 0;
        while (dd[0] !== 12'h555 && n < 20) begin @(negedge sys_clk); n++; end
        chk("single_sample", 32'(dd[0]), 32'h555);
        c0 = ucnt[0];
        pulses = 0;
        repeat (20) begin @(negedge sys_clk); if (und[0]) pulses++; end
        chk("underrun_pulses", 32'(pulses), 32'd10);
        chk("underrun_hold", 32'(dd[0]), 32'h555);
`ifdef DAC_TX_UNDERRUN_CNT_EN
        chk("underrun_cnt_delta", 32'(ucnt[0] - c0), 32'd10);
`endif

        // 3. backpressure with the divider stopped
        enable = 1'b0;
        clr_logs();
        @(negedge sys_clk);
        offer(12'h001, 0); offer(12'h002, 0); offer(12'h003, 0); offer(12'h004, 0);
        s_valid = 1'b1; s_data = 12'h005;
        repeat (3) begin
            chk("full_s_ready", 32'(rdy[0]), 32'd0);
            @(negedge sys_clk);
        end
        enable = 1'b1;
        offer(12'h005, 0);
        repeat (16) @(negedge sys_clk);
        chk("bp_len", 32'(log0.size()), 32'd5);
        for (int k = 0; k < 5; k++) chk("bp_order", 32'(log0[k]), 32'(k + 1));

        // reset mid-operation discards buffered data
        enable = 1'b0;
        offer(12'h0EE, 0); offer(12'h0EF, 0);
        rst_n = 1'b0;
        @(negedge sys_clk);
        chk("midrst_dac_d", 32'(dd[0]), 32'h800);
        chk("midrst_dac_clk", 32'(dclk[0]), 32'd0);
        rst_n = 1'b1; enable = 1'b1;
        repeat (2) @(negedge sys_clk);
        clr_logs();
        repeat (20) @(negedge sys_clk);
        chk("midrst_no_stale", 32'(log0.size()), 32'd0);

        // 6. DIV=3: clock period, pause and resume
        n = 0;
        prev_c = dclk[2];
        while (!(dclk[2] && !prev_c) && n < 30) begin prev_c = dclk[2]; @(negedge sys_clk); n++; end
        n = 0;
        prev_c = dclk[2];
        do begin prev_c = dclk[2]; @(negedge sys_clk); n++; end while (!(dclk[2] && !prev_c) && n < 30);
        chk("div3_period", 32'(n), 32'd6);
        clr_logs();
        @(negedge sys_clk);
        offer(12'h0A1, 2); offer(12'h0A2, 2); offer(12'h0A3, 2);
        n = 0;
        while (log2.size() < 1 && n < 30) begin @(negedge sys_clk); n++; end
        chk("div3_first", 32'(dd[2]), 32'h0A1);
        enable = 1'b0;
        snap = dd[2];
        @(negedge sys_clk);
        chk("pause_dac_clk", 32'(dclk[2]), 32'd0);
        chk("pause_dac_d", 32'(dd[2]), 32'(snap));
        repeat (8) @(negedge sys_clk);
        chk("pause_hold", 32'(dd[2]), 32'(snap));
        enable = 1'b1;
        n = 0;
        do begin @(negedge sys_clk); n++; end while (dd[2] === snap && n < 40);
        chk("resume_latency", 32'(n), 32'd6);
        chk("resume_sample", 32'(dd[2]), 32'h0A2);
        repeat (20) @(negedge sys_clk);
        chk("div3_len", 32'(log2.size()), 32'd3);
        chk("div3_last", 32'(log2[2]), 32'h0A3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
